// File: rtl/pri_decoder2.sv
// pri_decoder2: sequential 2-to-4 decoder for 3-bit priority codes.
// Codes 0..3 drive a one-hot line held for HOLD_CYCLES cycles, code 7 means
// "no request" and pulses none_flag, codes 4..6 are illegal and set a sticky
// err. Accepted legal codes are counted in a saturating 8-bit counter.
module pri_decoder2 #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       code_valid,
  input  logic [2:0] code,
  output logic       code_ready,
  input  logic       err_clr,
  output logic [3:0] line,
  output logic       line_valid,
  output logic       none_flag,
  output logic       err,
  output logic [7:0] evt_cnt
);

  // Hold counter is at least one bit wide so HOLD_CYCLES = 1 still elaborates.
  localparam int CNT_W = ($clog2(HOLD_CYCLES) > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_line;
  logic             r_line_valid;
  logic             r_none_flag;
  logic             r_err;
  logic [7:0]       r_evt_cnt;

  logic       w_accept;
  logic       w_legal;
  logic       w_none;
  logic       w_illegal;
  logic       w_final_hold;
  logic [3:0] w_onehot;

  // Classify the presented code: bit 2 clear means a line select.
  assign w_legal   = ~code[2];
  assign w_none    = (code == 3'd7);
  assign w_illegal = code[2] & ~w_none;

  // One-hot expansion of the low two code bits.
  for (genvar gi = 0; gi < 4; gi++) begin : g_onehot
    assign w_onehot[gi] = (code[1:0] == 2'(gi));
  end

  // Ready in IDLE, or in the last cycle of a hold so the next code can follow
  // without a gap in line_valid.
  assign w_final_hold = (r_state == ST_HOLD) && (r_cnt == CNT_ZERO);
  assign code_ready   = (r_state == ST_IDLE) || w_final_hold;
  assign w_accept     = code_valid && code_ready;

  // Control FSM with all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= CNT_ZERO;
      r_line       <= 4'b0000;
      r_line_valid <= 1'b0;
      r_none_flag  <= 1'b0;
      r_err        <= 1'b0;
      r_evt_cnt    <= 8'd0;
    end else begin
      // none_flag is a single-cycle pulse unless re-armed below.
      r_none_flag <= 1'b0;

      // Setting by an illegal accept takes priority over a clear request.
      if (w_accept && w_illegal) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end

      if (w_accept) begin
        if (w_legal) begin
          r_line       <= w_onehot;
          r_line_valid <= 1'b1;
          r_cnt        <= CNT_LOAD;
          r_state      <= ST_HOLD;
          if (r_evt_cnt != 8'hFF) begin
            r_evt_cnt <= r_evt_cnt + 8'd1;
          end
        end else begin
          // Code 7 or an illegal code: drop the line and return to IDLE.
          r_line       <= 4'b0000;
          r_line_valid <= 1'b0;
          r_cnt        <= CNT_ZERO;
          r_state      <= ST_IDLE;
          r_none_flag  <= w_none;
        end
      end else if (r_state == ST_HOLD) begin
        if (r_cnt != CNT_ZERO) begin
          r_cnt <= r_cnt - 1'b1;
        end else begin
          r_line       <= 4'b0000;
          r_line_valid <= 1'b0;
          r_state      <= ST_IDLE;
        end
      end
    end
  end

  assign line       = r_line;
  assign line_valid = r_line_valid;
  assign none_flag  = r_none_flag;
  assign err        = r_err;
  assign evt_cnt    = r_evt_cnt;

endmodule

// File: tb/tb_pri_decoder2.sv
// Bench for pri_decoder2: two instances (HOLD_CYCLES = 4 and 1) checked every
// cycle against a timeline model, plus directed literal checks.
module tb_pri_decoder2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] vld;
  logic [2:0] cd [2];
  logic [1:0] clr;
  logic [1:0] rdy;
  logic [1:0] lv;
  logic [1:0] nf;
  logic [1:0] er;
  logic [3:0] ln [2];
  logic [7:0] ev [2];

  pri_decoder2 #(.HOLD_CYCLES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .code_valid(vld[0]), .code(cd[0]),
    .code_ready(rdy[0]), .err_clr(clr[0]), .line(ln[0]), .line_valid(lv[0]),
    .none_flag(nf[0]), .err(er[0]), .evt_cnt(ev[0])
  );

  pri_decoder2 #(.HOLD_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .code_valid(vld[1]), .code(cd[1]),
    .code_ready(rdy[1]), .err_clr(clr[1]), .line(ln[1]), .line_valid(lv[1]),
    .none_flag(nf[1]), .err(er[1]), .evt_cnt(ev[1])
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: remembers when the last code was accepted and what it was; the
  // outputs follow from the cycle number relative to that accept.
  int cyc = 0;
  int m_acc  [2] = '{-100, -100};
  int m_code [2] = '{-1, -1};
  bit m_none [2] = '{1'b0, 1'b0};
  bit m_err  [2] = '{1'b0, 1'b0};
  int m_cnt  [2] = '{0, 0};

  function automatic int hold_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic bit m_lv(input int i);
    return (m_code[i] >= 0) && (m_code[i] <= 3) &&
           (cyc >= m_acc[i]) && (cyc <= m_acc[i] + hold_of(i) - 1);
  endfunction

  function automatic bit m_ready(input int i);
    return !m_lv(i) || (cyc == m_acc[i] + hold_of(i) - 1);
  endfunction

  function automatic int m_line(input int i);
    return m_lv(i) ? (1 << m_code[i]) : 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc <= 0;
      for (int i = 0; i < 2; i++) begin
        m_acc[i]  <= -100;
        m_code[i] <= -1;
        m_none[i] <= 1'b0;
        m_err[i]  <= 1'b0;
        m_cnt[i]  <= 0;
      end
    end else begin
      cyc <= cyc + 1;
      for (int i = 0; i < 2; i++) begin
        if (vld[i] && m_ready(i)) begin
          m_acc[i]  <= cyc + 1;
          m_code[i] <= int'(cd[i]);
          m_none[i] <= (cd[i] == 3'd7);
          if (cd[i] >= 3'd4 && cd[i] <= 3'd6) m_err[i] <= 1'b1;
          else if (clr[i]) m_err[i] <= 1'b0;
          if (cd[i] <= 3'd3 && m_cnt[i] < 255) m_cnt[i] <= m_cnt[i] + 1;
        end else begin
          m_none[i] <= 1'b0;
          if (clr[i]) m_err[i] <= 1'b0;
        end
      end
    end
  end

  // Per-cycle compare, mid-cycle away from the rising edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("i%0d.line", i), int'(ln[i]), m_line(i));
        chk($sformatf("i%0d.line_valid", i), int'(lv[i]), int'(m_lv(i)));
        chk($sformatf("i%0d.code_ready", i), int'(rdy[i]), int'(m_ready(i)));
        chk($sformatf("i%0d.none_flag", i), int'(nf[i]), int'(m_none[i]));
        chk($sformatf("i%0d.err", i), int'(er[i]), int'(m_err[i]));
        chk($sformatf("i%0d.evt_cnt", i), int'(ev[i]), m_cnt[i]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    vld = 2'b00; clr = 2'b00; cd[0] = 3'd0; cd[1] = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ready", int'(rdy[0]), 1);
    chk("rst.line", int'(ln[0]), 0);
    chk("rst.evt", int'(ev[0]), 0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    cmp_en = 1'b1;
    tick();

    // Code 2 with HOLD_CYCLES = 4.
    vld[0] = 1'b1; cd[0] = 3'd2;
    tick();
    vld[0] = 1'b0;
    chk("h4.T1.line", int'(ln[0]), 4);
    chk("h4.T1.lv", int'(lv[0]), 1);
    chk("h4.T1.ready", int'(rdy[0]), 0);
    chk("h4.T1.evt", int'(ev[0]), 1);
    tick(); chk("h4.T2.ready", int'(rdy[0]), 0);
    tick(); chk("h4.T3.ready", int'(rdy[0]), 0);
    tick(); chk("h4.T4.ready", int'(rdy[0]), 1);
    chk("h4.T4.line", int'(ln[0]), 4);
    tick(); chk("h4.T5.line", int'(ln[0]), 0);
    chk("h4.T5.lv", int'(lv[0]), 0);

    // Streaming with HOLD_CYCLES = 1.
    vld[1] = 1'b1; cd[1] = 3'd0;
    tick(); chk("h1.s0", int'(ln[1]), 1); cd[1] = 3'd1;
    tick(); chk("h1.s1", int'(ln[1]), 2); cd[1] = 3'd3;
    tick(); chk("h1.s2", int'(ln[1]), 8); cd[1] = 3'd2;
    tick(); chk("h1.s3", int'(ln[1]), 4); vld[1] = 1'b0;
    chk("h1.evt", int'(ev[1]), 4);
    tick();

    // Code 7 from IDLE, then code 7 in the final hold cycle of code 1.
    vld[0] = 1'b1; cd[0] = 3'd7;
    tick(); chk("none1.flag", int'(nf[0]), 1); chk("none1.line", int'(ln[0]), 0);
    chk("none1.evt", int'(ev[0]), 1);
    vld[0] = 1'b0;
    tick(); chk("none1.off", int'(nf[0]), 0);
    vld[0] = 1'b1; cd[0] = 3'd1;
    tick(); cd[0] = 3'd7;
    tick(); tick(); tick();
    chk("none2.final_ready", int'(rdy[0]), 1);
    chk("none2.final_line", int'(ln[0]), 2);
    tick(); chk("none2.flag", int'(nf[0]), 1); chk("none2.line", int'(ln[0]), 0);
    chk("none2.evt", int'(ev[0]), 2);
    vld[0] = 1'b0;
    tick(); chk("none2.off", int'(nf[0]), 0);

    // Sticky error and its clear.
    vld[0] = 1'b1; cd[0] = 3'd5;
    tick(); chk("err.set", int'(er[0]), 1); chk("err.evt", int'(ev[0]), 2);
    cd[0] = 3'd0;
    tick(); chk("err.sticky", int'(er[0]), 1); chk("err.evt2", int'(ev[0]), 3);
    vld[0] = 1'b0;
    tick(); tick(); tick();
    vld[0] = 1'b1; cd[0] = 3'd4; clr[0] = 1'b1;
    tick(); chk("err.setwins", int'(er[0]), 1); chk("err.line", int'(ln[0]), 0);
    vld[0] = 1'b0;
    tick(); chk("err.clr", int'(er[0]), 0);
    clr[0] = 1'b0;

    // Asynchronous reset in the middle of a hold.
    vld[0] = 1'b1; cd[0] = 3'd3;
    tick(); vld[0] = 1'b0;
    tick(); chk("ar.pre_line", int'(ln[0]), 8);
    #2; rst_n = 1'b0; #1;
    chk("ar.line", int'(ln[0]), 0);
    chk("ar.lv", int'(lv[0]), 0);
    chk("ar.ready", int'(rdy[0]), 1);
    chk("ar.evt", int'(ev[0]), 0);
    chk("ar.evt1", int'(ev[1]), 0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    tick();
    vld[0] = 1'b1; cd[0] = 3'd1;
    tick(); chk("ar.after_line", int'(ln[0]), 2); chk("ar.after_evt", int'(ev[0]), 1);

    // 300 accepts with code_valid held high; code wiggles while not ready.
    for (int k = 0; k < 300; k++) begin
      guard = 0;
      while (!m_ready(0) && guard < 10) begin
        cd[0] = 3'($urandom_range(0, 3));
        tick();
        guard++;
      end
      chk("sat.wait_bound", int'(guard < 10), 1);
      cd[0] = 3'(k % 4);
      tick();
    end
    vld[0] = 1'b0;
    chk("sat.evt", int'(ev[0]), 255);
    repeat (6) tick();
    chk("sat.evt_hold", int'(ev[0]), 255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pri_decoder2.md
# pri_decoder2

Sequential 2-to-4 decoder: the receiving end of the 3-bit priority code produced by the team's 4-input priority encoders (codes 0–3 select a line, 3'b111 means "no request"). It accepts codes over a valid/ready handshake and drives the matching one-hot line for a programmable number of cycles. It also flags "none" codes, latches a sticky error on illegal codes, and counts accepted legal codes. It sits downstream of the encoder, in front of per-line consumers that need a held strobe.

## Interface
Parameters:
- HOLD_CYCLES, 4: cycles each decoded line stays asserted; legal range 1..255.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- code_valid  in  1  a code is presented on `code`.
- code  in  3  encoded index: 0..3 select line, 7 means none, 4..6 are illegal.
- code_ready  out  1  the block can accept a code this cycle.
- err_clr  in  1  clears the sticky `err`.
- line  out  4  one-hot decoded line, registered.
- line_valid  out  1  `line` holds a decoded value.
- none_flag  out  1  one-cycle pulse after a code of 7 is accepted.
- err  out  1  sticky flag; set when an illegal code is accepted.
- evt_cnt  out  8  count of accepted legal codes (0..3); saturates at 255.

## Operation
- Accept event = `code_valid && code_ready` at a rising edge.
- States:
  - IDLE: no line is being held.
  - HOLD: a decoded line is being held; a down-counter runs.
  - The hold counter is max(1, $clog2(HOLD_CYCLES)) bits wide.
- `code_ready` is combinational: 1 in IDLE, and 1 in HOLD only when the counter is 0 (final hold cycle). Otherwise 0.
- Accept of code c in 0..3, from IDLE or from the final HOLD cycle:
  - line <= 4'b0001 << c; line_valid <= 1; counter <= HOLD_CYCLES-1; state <= HOLD.
  - evt_cnt increments by 1; held at 255 once reached, never wraps.
- Accept of code 7:
  - line <= 0; line_valid <= 0; none_flag <= 1 for one cycle; state <= IDLE.
- Accept of code 4, 5 or 6:
  - line <= 0; line_valid <= 0; err <= 1; state <= IDLE.
  - none_flag stays 0; evt_cnt is unchanged.
- In HOLD with no accept:
  - counter != 0: counter decrements; line is held.
  - counter == 0: line <= 0; line_valid <= 0; state <= IDLE.
- `err_clr` clears `err` on the next edge. If `err_clr` coincides with accepting an illegal code, set wins and `err` stays 1.
- `none_flag` is 0 in every cycle not immediately following a code-7 accept.
- `code_valid` while `code_ready` = 0 is ignored. No state change occurs and no buffering is done; the source must hold the code.

## Timing
- Reset (asynchronous, takes effect immediately, including mid-HOLD):
  - line = 0, line_valid = 0, none_flag = 0, err = 0, evt_cnt = 0.
  - state = IDLE, counter = 0, so code_ready = 1.
- Latency: accept at edge T gives `line`/`line_valid` valid from T+1, one cycle after acceptance.
- A legal code accepted at edge T holds `line` during cycles T+1 .. T+HOLD_CYCLES.
  - `code_ready` is high in cycle T+HOLD_CYCLES.
  - A code accepted at the end of that cycle takes effect at T+HOLD_CYCLES+1 with no gap in line_valid.
- HOLD_CYCLES = 1: `code_ready` is always 1, and the block decodes one code per cycle at full throughput.
- Back-to-back codes with a 1-cycle gap in `code_valid`: line_valid drops for exactly one cycle.
- All outputs except `code_ready` are registered.

## Test plan
- Reset, then with HOLD_CYCLES = 4 accept code 2 at edge T:
  - line = 4'b0100 and line_valid = 1 for cycles T+1..T+4; line = 0 at T+5.
  - code_ready = 0 at T+1..T+3 and 1 at T+4; evt_cnt = 1.
- Streaming, HOLD_CYCLES = 1: present codes 0, 1, 3, 2 on consecutive cycles.
  - line = 0001, 0010, 1000, 0100 on consecutive cycles; evt_cnt = 4; code_ready is never 0.
- Code 7 accepted from IDLE, then code 7 accepted in the final HOLD cycle of code 1:
  - none_flag pulses exactly one cycle each time.
  - line = 0 the cycle after each accept; evt_cnt does not change.
- Code 5 accepted: err = 1 and stays 1 across later legal codes. Then err_clr together with an accepted code 4: err stays 1. Then err_clr alone: err = 0 the next cycle.
- Assert rst_n = 0 mid-HOLD (line = 1000): all outputs go to 0 immediately (code_ready = 1) without waiting for clk; after release, code 1 decodes normally.
- 300 legal accepts: evt_cnt reaches 255 and holds there; code_valid held high while code_ready = 0 is never consumed (line sequence unchanged).
